// File: rtl/sdio_pkg.sv
// Shared state type and default timing for the SDIO card-ownership switch sequencer.
package sdio_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISOLATE = 3'd1,
    PWR_OFF = 3'd2,
    SWITCH  = 3'd3,
    PWR_ON  = 3'd4,
    CONNECT = 3'd5
  } sdio_sw_state_t;

  localparam int SDIO_ISO_CYCLES = 16;
  localparam int SDIO_OFF_CYCLES = 50000;
  localparam int SDIO_ON_CYCLES  = 50000;

  // Largest of the three wait lengths; sizes the shared wait counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sdio_wait_timer.sv
// Saturating wait counter shared by every timed state of the switch sequencer.
// expire is high while the count equals the terminal value supplied for the current state.
module sdio_wait_timer #(
  parameter int CNT_W = 4
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             clr,
  input  logic [CNT_W-1:0] tc,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  assign expire = (cnt == tc);

  // Count up from zero after each clear and hold at the terminal value (no wrap).
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!expire) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/sdio_switch_sequencer.sv
// Break-before-make SD card ownership switch: isolate, power off, flip mux, power on, reconnect.
// All outputs are registered from the next-state decode so they change on the state-entry edge.
module sdio_switch_sequencer
  import sdio_pkg::*;
#(
  parameter int ISO_CYCLES = SDIO_ISO_CYCLES,
  parameter int OFF_CYCLES = SDIO_OFF_CYCLES,
  parameter int ON_CYCLES  = SDIO_ON_CYCLES
) (
  input  logic pclk,
  input  logic presetn,
  input  logic sdio_control,
  output logic sdio_sel,
  output logic card_pwr_en,
  output logic bus_en,
  output logic busy,
  output logic switch_done
);

  localparam int CNT_W = $clog2(max3(ISO_CYCLES, OFF_CYCLES, ON_CYCLES) + 1);
  localparam logic [CNT_W-1:0] ISO_TC = CNT_W'(ISO_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_TC = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_TC  = CNT_W'(ON_CYCLES - 1);

  if ((ISO_CYCLES < 1) || (OFF_CYCLES < 1) || (ON_CYCLES < 1)) begin : g_bad_timing
    $error("sdio_switch_sequencer: every wait cycle count must be at least 1");
  end

  sdio_sw_state_t   state;
  sdio_sw_state_t   state_nx;
  logic             target;
  logic             clr;
  logic             expire;
  logic             pwr_up;
  logic [CNT_W-1:0] tc;

  // Reset parks in PWR_ON with the card unpowered; the first edge acts as the PWR_ON entry.
  assign pwr_up = (state == PWR_ON) && !card_pwr_en;

  // Terminal count for the wait state currently running.
  always_comb begin
    tc = ISO_TC;
    case (state)
      ISOLATE: tc = ISO_TC;
      PWR_OFF: tc = OFF_TC;
      PWR_ON:  tc = ON_TC;
      default: tc = ISO_TC;
    endcase
  end

  // Next-state decode; the timer restarts on every state entry.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (sdio_control != sdio_sel) state_nx = ISOLATE;
        else                          state_nx = IDLE;
      end
      ISOLATE: begin
        if (expire) state_nx = PWR_OFF;
        else        state_nx = ISOLATE;
      end
      PWR_OFF: begin
        if (expire) state_nx = SWITCH;
        else        state_nx = PWR_OFF;
      end
      SWITCH:  state_nx = PWR_ON;
      PWR_ON: begin
        if (card_pwr_en && expire) state_nx = CONNECT;
        else                       state_nx = PWR_ON;
      end
      CONNECT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    clr = (state_nx != state) || pwr_up;
  end

  sdio_wait_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .pclk    (pclk),
    .presetn (presetn),
    .clr     (clr),
    .tc      (tc),
    .expire  (expire)
  );

  // State, latched target and registered outputs; target is frozen once a sequence starts.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state       <= PWR_ON;
      target      <= 1'b0;
      sdio_sel    <= 1'b0;
      card_pwr_en <= 1'b0;
      bus_en      <= 1'b0;
      busy        <= 1'b1;
      switch_done <= 1'b0;
    end else begin
      state <= state_nx;
      if ((state == IDLE) && (state_nx == ISOLATE)) target <= sdio_control;
      else                                          target <= target;
      if (state == SWITCH) sdio_sel <= target;
      else                 sdio_sel <= sdio_sel;
      bus_en      <= (state_nx == IDLE) || (state_nx == CONNECT);
      card_pwr_en <= !((state_nx == PWR_OFF) || (state_nx == SWITCH));
      busy        <= (state_nx != IDLE);
      switch_done <= (state_nx == CONNECT);
    end
  end

endmodule

// File: tb/tb_sdio_switch_sequencer.sv
// Self-checking bench for sdio_switch_sequencer: timing tables, corner-case sequences and
// a randomized run against a timeline model (ISO=4, OFF=8, ON=16).
module tb_sdio_switch_sequencer;

  localparam int ISO = 4;
  localparam int OFF = 8;
  localparam int ON  = 16;
  localparam int SEQ = ISO + OFF + ON + 2;   // cycles from ISOLATE entry to IDLE entry

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  logic sdio_control = 1'b0;
  logic sdio_sel, card_pwr_en, bus_en, busy, switch_done;

  int checks = 0;
  int failures = 0;
  int rel = 0;
  logic prev_sel = 1'b0;

  // Timeline model: position inside a sequence rather than a state machine.
  bit   m_pre, m_act;
  int   m_t;
  logic m_tgt, m_sel;

  typedef struct {
    int         rel;
    logic [4:0] exp;   // {sdio_sel, card_pwr_en, bus_en, busy, switch_done}
    string      name;
  } vec_t;
  vec_t tbl[12];

  always #5 pclk = ~pclk;

  sdio_switch_sequencer #(
    .ISO_CYCLES (ISO),
    .OFF_CYCLES (OFF),
    .ON_CYCLES  (ON)
  ) dut (
    .pclk         (pclk),
    .presetn      (presetn),
    .sdio_control (sdio_control),
    .sdio_sel     (sdio_sel),
    .card_pwr_en  (card_pwr_en),
    .bus_en       (bus_en),
    .busy         (busy),
    .switch_done  (switch_done)
  );

  function automatic logic [4:0] outs();
    return {sdio_sel, card_pwr_en, bus_en, busy, switch_done};
  endfunction

  function automatic logic [4:0] model_outs();
    if (m_pre)  return {m_sel, 4'b0010};
    if (!m_act) return {m_sel, 4'b1100};
    return {m_sel, !((m_t >= ISO) && (m_t <= ISO + OFF)), (m_t == SEQ - 1), 1'b1, (m_t == SEQ - 1)};
  endfunction

  task automatic model_reset();
    m_pre = 1'b1; m_act = 1'b1; m_t = 0; m_tgt = 1'b0; m_sel = 1'b0;
  endtask

  task automatic model_step(input logic ctrl);
    if (m_pre) begin
      m_pre = 1'b0; m_act = 1'b1; m_t = ISO + OFF + 1; m_tgt = 1'b0;
    end else if (m_act) begin
      m_t++;
      if (m_t == ISO + OFF + 1) m_sel = m_tgt;
      if (m_t == SEQ) m_act = 1'b0;
    end else if (ctrl != m_sel) begin
      m_act = 1'b1; m_t = 0; m_tgt = ctrl;
    end
  endtask

  task automatic check_v(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got {sel,pwr,bus,busy,done}=%b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_n(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    model_step(sdio_control);
    #1;
    rel++;
    check_v("model", outs(), model_outs());
    check_n("inv_pwr_bus", int'(bus_en & ~card_pwr_en), 0);
    check_n("inv_sel_bus", int'(bus_en & (sdio_sel ^ prev_sel)), 0);
    prev_sel = sdio_sel;
  endtask

  task automatic run_tbl(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      while (rel < tbl[i].rel) tick();
      check_v(tbl[i].name, outs(), tbl[i].exp);
    end
  endtask

  initial begin
    int dones, idle_gap, chg, first_sel;
    logic [4:0] snap;

    tbl[0]  = '{1,  5'b01010, "pu_edge1"};
    tbl[1]  = '{16, 5'b01010, "pu_on_end"};
    tbl[2]  = '{17, 5'b01111, "pu_connect"};
    tbl[3]  = '{18, 5'b01100, "pu_idle"};
    tbl[4]  = '{1,  5'b01010, "sw_isolate"};
    tbl[5]  = '{4,  5'b01010, "sw_iso_end"};
    tbl[6]  = '{5,  5'b00010, "sw_pwr_off"};
    tbl[7]  = '{13, 5'b00010, "sw_switch"};
    tbl[8]  = '{14, 5'b11010, "sw_pwr_on"};
    tbl[9]  = '{29, 5'b11010, "sw_on_end"};
    tbl[10] = '{30, 5'b11111, "sw_connect"};
    tbl[11] = '{31, 5'b11100, "sw_idle"};

    // Test 1: reset values, then the post-reset power-up sequence.
    model_reset();
    #12;
    check_v("reset_vals", outs(), 5'b00010);
    @(posedge pclk); #1;
    presetn = 1'b1;
    rel = 0;
    run_tbl(0, 3);

    // Test 2: host0 -> host1 switch timing from IDLE.
    sdio_control = 1'b1;
    rel = 0;
    run_tbl(4, 11);

    // Test 3: toggle back during PWR_OFF; completes to latched target, one IDLE cycle, returns.
    sdio_control = 1'b0;
    rel = 0;
    repeat (8) tick();
    sdio_control = 1'b1;
    dones = 0; idle_gap = 0; first_sel = -1;
    repeat (80) begin
      tick();
      if (switch_done) begin
        dones++;
        if (dones == 1) first_sel = int'(sdio_sel);
      end
      if (!busy && dones == 1) idle_gap++;
    end
    check_n("toggle_dones", dones, 2);
    check_n("toggle_first_sel", first_sel, 0);
    check_n("toggle_idle_gap", idle_gap, 1);
    check_n("toggle_final_sel", int'(sdio_sel), 1);

    // Test 4: asynchronous reset during PWR_OFF, then power-up again with sdio_sel=0.
    sdio_control = 1'b0;
    rel = 0;
    repeat (8) tick();
    #2;
    presetn = 1'b0;
    #1;
    check_v("rst_async", outs(), 5'b00010);
    model_reset();
    @(posedge pclk); #1;
    check_v("rst_hold", outs(), 5'b00010);
    presetn = 1'b1;
    rel = 0;
    run_tbl(0, 3);

    // Test 5: request equals owner for 1000 cycles; nothing may move.
    snap = outs();
    chg = 0; dones = 0;
    repeat (1000) begin
      tick();
      if (outs() !== snap) chg++;
      if (switch_done) dones++;
    end
    check_n("hold_changes", chg, 0);
    check_n("hold_dones", dones, 0);

    // Test 6: random toggling against the model, then settle on the last request.
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 39) == 0) sdio_control = ~sdio_control;
      tick();
    end
    repeat (70) tick();
    check_n("rand_final_sel", int'(sdio_sel), int'(sdio_control));
    check_n("rand_final_idle", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
